// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data-side SRAM responder.
// The DATA_SRAM_RAND_STALL_EN build uses the LFSR constants below.
package data_sram_responder_pkg;

    localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
    localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
        logic [7:0]  stamp;
    } resp_entry_t;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1, shifting toward the MSB.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/data_sram_resp_fifo.sv
// Circular response queue for the SRAM responder.
// Push and pop in the same cycle are allowed, including when the queue is full.
module data_sram_resp_fifo
    import data_sram_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  resp_entry_t                push_data,
    input  logic                       pop,
    output resp_entry_t                pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);

    resp_entry_t         storage [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) storage[wr_ptr] <= push_data;
    end

    assign pop_data = storage[rd_ptr];
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);

    a_no_overflow:  assert property (@(posedge clk) disable iff (!resetn) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!resetn) !(pop && empty));

endmodule

// File: rtl/data_sram_responder.sv
// Slave end of the SRAM-like data interface: in-order responses after a fixed latency.
// Defining DATA_SRAM_RAND_STALL_EN adds LFSR-driven accept and retire stalls.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH      = 12,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Handshake: a request transfers on any rising edge where req && addr_ok;
    // addr_ok is combinational from req, and data_ok is a one-cycle pulse
    // that the master must always take (no back-pressure on responses).

    logic [31:0]                      mem [DEPTH];
    logic [ADDR_WIDTH-1:0]            word_idx;
    logic [7:0]                       now;
    logic [7:0]                       head_age;
    resp_entry_t                      push_entry;
    resp_entry_t                      head;
    logic                             push;
    logic                             pop;
    logic                             full;
    logic                             empty;
    logic                             head_ready;
    logic                             accept_stall;
    logic                             retire_stall;
    logic [$clog2(MAX_OUTSTANDING):0] count;
    logic                             unused_bits;

    assign word_idx    = data_sram_addr[ADDR_WIDTH+1:2];
    assign unused_bits = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0], data_sram_size};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) now <= 8'd0;
        else         now <= now + 8'd1;
    end

`ifdef DATA_SRAM_RAND_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= LFSR_SEED;
        else         lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    assign accept_stall = (lfsr[1:0] == 2'b00);
    assign retire_stall = (lfsr[3:2] == 2'b00);
`else
    assign accept_stall = 1'b0;
    assign retire_stall = 1'b0;
`endif

    // Age is modulo 256, so a stamp stays meaningful for 255 cycles after acceptance.
    assign head_age   = now - head.stamp;
    assign head_ready = !empty && (head_age >= 8'(LATENCY));
    assign pop        = head_ready && !retire_stall;

    assign data_sram_addr_ok = resetn && data_sram_req && (!full || pop) && !accept_stall;
    assign push              = data_sram_req && data_sram_addr_ok;

    assign push_entry = '{is_read: !data_sram_wr,
                          data:    data_sram_wr ? 32'h0 : mem[word_idx],
                          stamp:   now};

    assign data_sram_data_ok = pop;
    assign data_sram_rdata   = (pop && head.is_read) ? head.data : 32'h0;

    always_ff @(posedge clk) begin
        if (push && data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wstrb[i]) mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    data_sram_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    a_count_range: assert property (@(posedge clk) disable iff (!resetn)
        32'(count) <= MAX_OUTSTANDING);
    a_size_legal:  assert property (@(posedge clk) disable iff (!resetn)
        !(push && (data_sram_size > SRAM_SIZE_WORD)));

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: vector table on a LATENCY=2 instance,
// queue-full and mid-operation reset sequences on a LATENCY=8 instance.
module tb_data_sram_responder;

    localparam int LAT  = 2;
    localparam int LAT8 = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    logic        req8, wr8;
    logic [1:0]  size8;
    logic [3:0]  wstrb8;
    logic [31:0] addr8, wdata8;
    logic        addr_ok8, data_ok8;
    logic [31:0] rdata8;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_q[$];
    time         acc_q[$];

    data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(LAT), .MAX_OUTSTANDING(4)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .data_sram_req     (req),
        .data_sram_wr      (wr),
        .data_sram_size    (size),
        .data_sram_wstrb   (wstrb),
        .data_sram_addr    (addr),
        .data_sram_wdata   (wdata),
        .data_sram_addr_ok (addr_ok),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata)
    );

    data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(LAT8), .MAX_OUTSTANDING(4)) dut8 (
        .clk               (clk),
        .resetn            (resetn),
        .data_sram_req     (req8),
        .data_sram_wr      (wr8),
        .data_sram_size    (size8),
        .data_sram_wstrb   (wstrb8),
        .data_sram_addr    (addr8),
        .data_sram_wdata   (wdata8),
        .data_sram_addr_ok (addr_ok8),
        .data_sram_data_ok (data_ok8),
        .data_sram_rdata   (rdata8)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Driver: present one request on the LATENCY=2 port and hold it until accepted.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] e, output int waits);
        req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2;
        waits = 0;
        @(negedge clk);
        while (!addr_ok && waits < 64) begin
            waits++;
            @(negedge clk);
        end
        if (addr_ok) begin
            exp_q.push_back(e);
            acc_q.push_back($time);
        end else begin
            check("accept_timeout", 32'(addr_ok), 32'h1);
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    // Scoreboard: every data_ok pops the oldest expectation.
    always @(negedge clk) begin
        if (resetn && data_ok) begin
            if (exp_q.size() == 0) begin
                check("unexpected_data_ok", 32'(data_ok), 32'h0);
            end else begin
                logic [31:0] e;
                time         t0;
                int          lat;
                e   = exp_q.pop_front();
                t0  = acc_q.pop_front();
                lat = int'(($time - t0) / 10);
                check("rdata", rdata, e);
`ifdef DATA_SRAM_RAND_STALL_EN
                check("latency_min", 32'(lat >= LAT), 32'h1);
`else
                check("latency", 32'(lat), 32'(LAT));
`endif
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'h0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int          waits;
        logic [19:0] aok_v, dok_v;
        logic [9:0]  rdok_v;
        int          acc, stale, lat;
        logic [31:0] got;

        vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,        4'h0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAAAAAAAA, 4'h4, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,        4'h0, 32'h11AA3344};
        vecs[5]  = '{1'b1, 32'h0000_4008, 32'h5A5A5A5A, 4'hF, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0008, 32'h0,        4'h0, 32'h5A5A5A5A};
        vecs[7]  = '{1'b1, 32'h0000_0030, 32'h00000000, 4'hF, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0030, 32'hFFFFFFFF, 4'h0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0030, 32'h0,        4'h0, 32'h00000000};
        vecs[10] = '{1'b1, 32'h0000_3FFC, 32'h12345678, 4'hF, 32'h0};
        vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0, 32'h12345678};
        vecs[12] = '{1'b1, 32'h0000_0040, 32'h00000000, 4'hF, 32'h0};
        vecs[13] = '{1'b1, 32'h0000_0040, 32'hCAFEF00D, 4'h9, 32'h0};
        vecs[14] = '{1'b0, 32'h0000_0040, 32'h0,        4'h0, 32'hCA00000D};

        // Reset state, with req held high to show addr_ok stays low.
        resetn = 1'b0;
        req = 1'b1; wr = 1'b0; size = 2'd2; wstrb = 4'h0; addr = '0; wdata = '0;
        req8 = 1'b1; wr8 = 1'b0; size8 = 2'd2; wstrb8 = 4'h0; addr8 = '0; wdata8 = '0;
        #3;
        check("rst_addr_ok",  32'(addr_ok),  32'h0);
        check("rst_data_ok",  32'(data_ok),  32'h0);
        check("rst_rdata",    rdata,         32'h0);
        check("rst_addr_ok8", 32'(addr_ok8), 32'h0);
        req = 1'b0; req8 = 1'b0;
        #9 resetn = 1'b1;
        @(posedge clk); #1;

`ifndef DATA_SRAM_RAND_STALL_EN
        // Vector table, back-to-back on the LATENCY=2 instance.
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_rdata, waits);
            check("accept_wait", 32'(waits), 32'h0);
        end
        wait_drain();

        // Queue full on the LATENCY=8 instance: seed a word, then present five reads.
        req8 = 1'b1; wr8 = 1'b1; addr8 = 32'h0; wdata8 = 32'h0BADF00D; wstrb8 = 4'hF;
        @(negedge clk);
        check("q8_setup_addr_ok", 32'(addr_ok8), 32'h1);
        @(posedge clk); #1;
        req8 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        aok_v = '0; dok_v = '0; acc = 0;
        for (int k = 0; k < 20; k++) begin
            req8 = (acc < 5); wr8 = 1'b0; addr8 = 32'h0;
            @(negedge clk);
            aok_v[k] = addr_ok8;
            dok_v[k] = data_ok8;
            if (data_ok8) check("q8_rdata", rdata8, 32'h0BADF00D);
            if (req8 && addr_ok8) acc++;
            @(posedge clk); #1;
        end
        req8 = 1'b0;
        check("q8_addr_ok_pattern", 32'(aok_v), 32'h0010F);
        check("q8_data_ok_pattern", 32'(dok_v), 32'h10F00);

        // Mid-operation reset: write, three reads, reset while the first read retires.
        rdok_v = '0;
        for (int k = 0; k < 10; k++) begin
            req8 = (k <= 3) || (k == 9);
            wr8  = (k == 0);
            addr8  = (k == 0) ? 32'h44 : 32'h0;
            wdata8 = 32'h600DCAFE;
            wstrb8 = 4'hF;
            @(negedge clk);
            rdok_v[k] = data_ok8;
            if (k < 9) begin
                @(posedge clk); #1;
            end
        end
        check("rst8_data_ok_pattern", 32'(rdok_v), 32'h300);
        check("rst8_pre_addr_ok", 32'(addr_ok8), 32'h1);
        check("rst8_pre_rdata",   rdata8,        32'h0BADF00D);
        #2 resetn = 1'b0;
        #1;
        check("rst8_addr_ok", 32'(addr_ok8), 32'h0);
        check("rst8_data_ok", 32'(data_ok8), 32'h0);
        check("rst8_rdata",   rdata8,        32'h0);
        req8 = 1'b0;
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk); #1;
        stale = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (data_ok8 || data_ok) stale++;
        end
        check("rst8_stale_data_ok", 32'(stale), 32'h0);
        @(posedge clk); #1;
        req8 = 1'b1; wr8 = 1'b0; addr8 = 32'h44;
        @(negedge clk);
        check("rst8_read_addr_ok", 32'(addr_ok8), 32'h1);
        @(posedge clk); #1;
        req8 = 1'b0;
        lat = 0; got = 32'h0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (data_ok8) begin
                lat = i;
                got = rdata8;
            end
            @(posedge clk); #1;
        end
        check("rst8_write_kept", got,        32'h600DCAFE);
        check("rst8_read_lat",   32'(lat),   32'(LAT8));
`else
        // Random mixed traffic against a reference memory, with stalls active.
        begin
            logic [31:0] ref_mem [16];
            logic        w;
            int          idx;
            logic [31:0] a, d;
            logic [3:0]  s;
            for (int i = 0; i < 16; i++) begin
                ref_mem[i] = $urandom;
                issue(1'b1, 32'(i) << 2, ref_mem[i], 4'hF, 32'h0, waits);
            end
            for (int n = 0; n < 1000; n++) begin
                w   = 1'($urandom_range(0, 1));
                idx = $urandom_range(0, 15);
                a   = (32'($urandom_range(0, 3)) << 14) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
                d   = $urandom;
                s   = 4'($urandom_range(0, 15));
                if (w) begin
                    issue(1'b1, a, d, s, 32'h0, waits);
                    ref_mem[idx] = merge(ref_mem[idx], d, s);
                end else begin
                    issue(1'b0, a, d, s, ref_mem[idx], waits);
                end
                if ($urandom_range(0, 7) == 0) begin
                    @(posedge clk); #1;
                end
            end
        end
`endif

        wait_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
